// File: rtl/uart_mem_dma.sv
// UART <-> memory transfer engine: `receive` fills WORD_COUNT words from rx,
// `send` streams WORD_COUNT words from memory out on tx.
module uart_mem_dma #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int WORD_COUNT   = 256,
  parameter int BYTE_ORDER   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              send,
  input  logic              receive,
  input  logic              rx,
  output logic              tx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              rx_LED,
  output logic              tx_LED,
  output logic              frame_err,
  output logic              done
);
  localparam int BPW   = DATA_W / 8;
  localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BC_W-1:0]   BYTE_LAST = BC_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WORD_COUNT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RX_XFER, S_TX_FETCH, S_TX_LOAD, S_TX_XFER, S_FIN} state_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_e;

  function automatic logic [7:0] first_byte(input logic [DATA_W-1:0] w);
    return (BYTE_ORDER == 0) ? w[7:0] : w[DATA_W-1 -: 8];
  endfunction

  function automatic logic [DATA_W-1:0] drop_byte(input logic [DATA_W-1:0] w);
    return (BYTE_ORDER == 0) ? (w >> 8) : (w << 8);
  endfunction

  function automatic logic [DATA_W-1:0] add_byte(input logic [DATA_W-1:0] w, input logic [7:0] b);
    return (BYTE_ORDER == 0) ? ((w >> 8) | (DATA_W'(b) << (DATA_W - 8)))
                             : ((w << 8) | DATA_W'(b));
  endfunction

  state_e            state_q, state_d;
  rx_state_e         rx_state_q, rx_state_d;
  logic              send_prev_q, receive_prev_q;
  logic              rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              mem_we_q, mem_we_d;
  logic              frame_err_q, frame_err_d;
  logic              tx_active_q, tx_active_d;
  logic [9:0]        tx_frame_q, tx_frame_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic              rx_rise, tx_rise, rx_valid, rx_bad;
  logic              tx_bit_end, tx_frame_end, tx_word_end, last_word;

  // Loaded in and out of reset alike, so a button held through reset never looks like an edge.
  always_ff @(posedge clk) begin
    send_prev_q    <= send;
    receive_prev_q <= receive;
  end

  assign rx_rise = receive & ~receive_prev_q;
  assign tx_rise = send & ~send_prev_q & ~rx_rise;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      R_IDLE: if (!rx_sync_q) begin
        rx_state_d = R_START;
        rx_cnt_d   = '0;
      end
      R_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      R_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      R_STOP: if (rx_cnt_q == BIT_LAST) rx_state_d = R_WAIT;
              else rx_cnt_d = rx_cnt_q + 1'b1;
      R_WAIT: if (rx_sync_q) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rx_valid = (rx_state_q == R_STOP) && (rx_cnt_q == BIT_LAST) &&  rx_sync_q;
    rx_bad   = (rx_state_q == R_STOP) && (rx_cnt_q == BIT_LAST) && !rx_sync_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  assign tx_bit_end   = tx_active_q && (tx_cnt_q == BIT_LAST);
  assign tx_frame_end = tx_bit_end && (tx_bit_q == 4'd9);
  assign tx_word_end  = tx_frame_end && (byte_cnt_q == BYTE_LAST);
  assign last_word    = (addr_q == ADDR_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (rx_rise) state_d = S_RX_XFER;
                  else if (tx_rise) state_d = S_TX_FETCH;
      S_RX_XFER:  if (mem_we_q && last_word) state_d = S_FIN;
      S_TX_FETCH: state_d = S_TX_LOAD;
      S_TX_LOAD:  state_d = S_TX_XFER;
      S_TX_XFER:  if (tx_word_end) state_d = last_word ? S_FIN : S_TX_FETCH;
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    rx_LED = (state_q == S_RX_XFER);
    tx_LED = (state_q == S_TX_FETCH) || (state_q == S_TX_LOAD) || (state_q == S_TX_XFER);
    done   = (state_q == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q      <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_active_q <= 1'b0;
      tx_frame_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
    end else begin
      addr_q      <= addr_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      frame_err_q <= frame_err_d;
      tx_active_q <= tx_active_d;
      tx_frame_q  <= tx_frame_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
    end
  end

  always_comb begin
    addr_d      = addr_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    frame_err_d = frame_err_q;
    tx_active_d = tx_active_q;
    tx_frame_d  = tx_frame_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    case (state_q)
      S_IDLE: if (rx_rise) begin
        addr_d      = '0;
        byte_cnt_d  = '0;
        frame_err_d = 1'b0;
      end else if (tx_rise) begin
        addr_d     = '0;
        byte_cnt_d = '0;
      end
      S_RX_XFER: begin
        if (rx_valid) begin
          word_d = add_byte(word_q, rx_shift_q);
          if (byte_cnt_q == BYTE_LAST) begin
            byte_cnt_d = '0;
            mem_we_d   = 1'b1;
          end else byte_cnt_d = byte_cnt_q + 1'b1;
        end
        if (mem_we_q) addr_d = addr_q + 1'b1;
      end
      // The first byte comes straight from mem_rdata so its start bit leads the first XFER cycle.
      S_TX_LOAD: begin
        word_d      = drop_byte(mem_rdata);
        tx_frame_d  = {1'b1, first_byte(mem_rdata), 1'b0};
        tx_active_d = 1'b1;
        tx_cnt_d    = '0;
        tx_bit_d    = '0;
      end
      S_TX_XFER: if (tx_bit_end) begin
        tx_cnt_d = '0;
        if (tx_frame_end) begin
          if (byte_cnt_q == BYTE_LAST) begin
            byte_cnt_d  = '0;
            tx_active_d = 1'b0;
            addr_d      = addr_q + 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            word_d     = drop_byte(word_q);
            tx_frame_d = {1'b1, first_byte(word_q), 1'b0};
            tx_bit_d   = '0;
          end
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_frame_d = {1'b1, tx_frame_q[9:1]};
        end
      end else if (tx_active_q) tx_cnt_d = tx_cnt_q + 1'b1;
      default: ;
    endcase
    if (rx_bad) frame_err_d = 1'b1;
  end

  assign tx        = tx_active_q ? tx_frame_q[0] : 1'b1;
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign mem_we    = mem_we_q;
  assign frame_err = frame_err_q;
endmodule
